// File: rtl/pet_pkg.sv
// pet_pkg: pet state encoding, need indices and a small helper.
// Shared by the pet needs controller and its tick generator.
package pet_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_NEUTRAL = 3'd1,
    ST_NEEDY   = 3'd2,
    ST_SLEEP   = 3'd3,
    ST_DEATH   = 3'd4
  } pet_state_e;

  localparam int NEED_REST = 0;
  localparam int NEED_FOOD = 1;
  localparam int NEED_FUN  = 2;

  function automatic int max_i(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int NUM_PET_NEEDS = max_i(NEED_FOOD, NEED_FUN) + 1;

endpackage

// File: rtl/pet_needs_controller_if.sv
// pet_needs_controller_if: buttons in, levels/state/tick out.
// master = button front-end side, slave = controller side.
interface pet_needs_controller_if #(
  parameter int NUM_NEEDS = 3,
  parameter int LEVEL_W   = 3,
  parameter int TEST_W    = 4
);
  import pet_pkg::*;

  logic [NUM_NEEDS-1:0]         btn_care;
  logic                         btn_sleep;
  logic                         btn_awake;
  logic                         btn_test;
  logic [TEST_W-1:0]            test_speed;
  logic [NUM_NEEDS*LEVEL_W-1:0] need_level;
  logic [NUM_NEEDS-1:0]         need_low;
  logic [STATE_W-1:0]           state;
  logic                         tick;

  modport master (
    output btn_care, btn_sleep, btn_awake,
    output btn_test, test_speed,
    input  need_level, need_low, state, tick
  );

  modport slave (
    input  btn_care, btn_sleep, btn_awake,
    input  btn_test, test_speed,
    output need_level, need_low, state, tick
  );

endinterface

// File: rtl/pet_tick_gen.sv
// pet_tick_gen: prescaler with latched speed, one-cycle tick.
// Ports: clk, rst (async low), load, speed, tick.
module pet_tick_gen
  import pet_pkg::*;
#(
  parameter int TICK_DIV = 20,
  parameter int TEST_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TEST_W-1:0] speed,
  output logic              tick
);

  localparam int AW = max_i($clog2(TICK_DIV), TEST_W) + 1;

  logic [TEST_W-1:0] speed_q;
  logic [AW-1:0]     acc_q;
  logic [AW-1:0]     sum;
  logic              hit;

  assign sum = acc_q + AW'(speed_q) + AW'(1);
  assign hit = (sum >= AW'(TICK_DIV));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      speed_q <= '0;
      acc_q   <= '0;
      tick    <= 1'b0;
    end else begin
      tick  <= hit;
      acc_q <= hit ? '0 : sum;
      if (load)
        speed_q <= speed;
    end
  end

endmodule

// File: rtl/pet_needs_controller.sv
// pet_needs_controller: need levels, starvation and pet FSM.
// Ports: clk, rst (async low), bus (slave). Option: PET_AUTOSLEEP_EN.
module pet_needs_controller
  import pet_pkg::*;
#(
  parameter int NUM_NEEDS   = NUM_PET_NEEDS,
  parameter int LEVEL_W     = 3,
  parameter int TICK_DIV    = 20,
  parameter int LOW_TH      = 2,
  parameter int CARE_STEP   = 2,
  parameter int DEATH_TICKS = 4,
  parameter int TEST_W      = 4
) (
  input logic                   clk,
  input logic                   rst,
  pet_needs_controller_if.slave bus
);

  localparam int LW2 = LEVEL_W + 2;
  localparam int CW  = $clog2(DEATH_TICKS + 1);
  localparam logic [LEVEL_W-1:0] MAX = '1;

  pet_state_e state_q, state_d;

  logic [LEVEL_W-1:0] lvl_q [NUM_NEEDS];
  logic [LEVEL_W-1:0] lvl_d [NUM_NEEDS];
  logic [LW2-1:0]     nxt   [NUM_NEEDS];
  logic [NUM_NEEDS-1:0] low_q, low_d, zero;
  logic [CW-1:0] starve_q;
  logic parity_q;
  logic tick, sleeping, dead, active;
  logic any_low, starved;

  assign sleeping = (state_q == ST_SLEEP);
  assign dead     = (state_q == ST_DEATH);
  assign active   = (state_q == ST_NEUTRAL) ||
                    (state_q == ST_NEEDY);
  assign any_low  = |low_q;
  assign starved  = (starve_q == CW'(DEATH_TICKS));

  pet_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TEST_W   (TEST_W)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .load  (bus.btn_test & ~dead),
    .speed (bus.test_speed),
    .tick  (tick)
  );

  // One combined update; the top bit of nxt flags underflow.
  always_comb begin
    for (int i = 0; i < NUM_NEEDS; i++) begin
      nxt[i] = {2'b00, lvl_q[i]};
      if (active && bus.btn_care[i])
        nxt[i] = nxt[i] + LW2'(CARE_STEP);
      if (!sleeping)
        nxt[i] = nxt[i] - LW2'(tick);
      else if (i == NEED_REST)
        nxt[i] = nxt[i] + LW2'(tick);
      else
        nxt[i] = nxt[i] - LW2'(tick & parity_q);
      if (nxt[i][LW2-1])
        lvl_d[i] = '0;
      else if (nxt[i][LW2-2:LEVEL_W] != '0)
        lvl_d[i] = MAX;
      else
        lvl_d[i] = nxt[i][LEVEL_W-1:0];
      low_d[i] = (lvl_d[i] <= LEVEL_W'(LOW_TH));
    end
  end

  always_comb begin
    zero = '0;
    for (int i = 0; i < NUM_NEEDS; i++)
      zero[i] = (lvl_q[i] == '0);
`ifdef PET_AUTOSLEEP_EN
    // exhausted rest sends the pet to sleep, not to death
    zero[NEED_REST] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_NEEDS; i++)
        lvl_q[i] <= MAX;
      low_q    <= '0;
      starve_q <= '0;
      parity_q <= 1'b0;
    end else begin
      if (!dead) begin
        for (int i = 0; i < NUM_NEEDS; i++)
          lvl_q[i] <= lvl_d[i];
        low_q <= low_d;
      end
      if (!sleeping)
        parity_q <= 1'b0;
      else if (tick)
        parity_q <= ~parity_q;
      if (tick) begin
        if (!(|zero))
          starve_q <= '0;
        else if (!starved)
          starve_q <= starve_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (starved) begin
      state_d = ST_DEATH;
    end else begin
      unique case (state_q)
        ST_IDLE:
          if (tick) state_d = ST_NEUTRAL;
        ST_SLEEP:
          if (bus.btn_awake || lvl_q[NEED_REST] == MAX)
            state_d = any_low ? ST_NEEDY : ST_NEUTRAL;
        ST_NEUTRAL, ST_NEEDY: begin
          if (bus.btn_sleep && !bus.btn_awake)
            state_d = ST_SLEEP;
`ifdef PET_AUTOSLEEP_EN
          else if (lvl_q[NEED_REST] == '0)
            state_d = ST_SLEEP;
`endif
          else
            state_d = any_low ? ST_NEEDY : ST_NEUTRAL;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_pack
    assign bus.need_level[g*LEVEL_W +: LEVEL_W] = lvl_q[g];
  end

  assign bus.need_low = low_q;
  assign bus.state    = state_q;
  assign bus.tick     = tick;

endmodule

// File: doc/pet_needs_controller.md
Name: pet_needs_controller

Overview:
Parametrised successor to the pet control unit. It tracks NUM_NEEDS independent need levels (rest, food, fun, ...). Each level decays on a prescaled time tick and is restored by care buttons. A registered FSM derives the pet state: idle, neutral, needy, sleeping or dead. The block sits between the debounced button front-end and the display/sprite logic, and supports a latched test-speed mode for accelerated simulation and demo.

Parameters:
NUM_NEEDS, 3, number of need channels; index 0 is always rest
LEVEL_W, 3, level width; MAX = 2^LEVEL_W-1
TICK_DIV, 20, prescaler accumulator limit per decay tick in normal mode
LOW_TH, 2, a level <= LOW_TH marks that need as low
CARE_STEP, 2, amount a care press adds to a level
DEATH_TICKS, 4, consecutive ticks with any level at 0 before DEATH
TEST_W, 4, width of test_speed

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
btn_care  in  NUM_NEEDS  per-need care pulse (debounced, one cycle)
btn_sleep  in  1  sleep request pulse
btn_awake  in  1  wake request pulse
btn_test  in  1  latch test_speed pulse
test_speed  in  TEST_W  prescaler step-1; 0 = normal speed
need_level  out  NUM_NEEDS*LEVEL_W  packed levels, need i at [i*LEVEL_W +: LEVEL_W]
need_low  out  NUM_NEEDS  per-need low flag
state  out  3  pet state, package encoding
tick  out  1  one-cycle decay tick strobe

Behaviour:
- Reset (rst=0, async): all levels = MAX; need_low = 0; state = IDLE; tick = 0; prescaler = 0; speed register = 0; starvation counter = 0; sleep parity = 0.
- Prescaler:
  - step = speed_reg + 1. Each cycle: if acc + step >= TICK_DIV, then tick=1 for one cycle and acc <= 0; else acc <= acc + step.
  - btn_test loads speed_reg from test_speed; the new step applies from the next cycle.
  - The sum is computed at max(clog2(TICK_DIV), TEST_W) + 1 bits.
- Level update (one combined update per cycle, intermediate at LEVEL_W+2 bits, clamped to 0..MAX):
  - new = level + (care_i ? CARE_STEP : 0) - dec_i + inc_i.
  - Outside SLEEP: dec_i = tick for every i; inc = 0.
  - In SLEEP:
    - need 0 gets inc = tick and dec = 0;
    - other needs get dec = tick AND parity, so they decay at half rate; parity toggles on each tick while sleeping and clears on exit;
    - btn_care is ignored.
  - DEATH: levels freeze and all buttons are ignored.
- need_low[i] = registered (level_i <= LOW_TH), updated together with the levels.
- Starvation counter: on each tick, increments (saturating at DEATH_TICKS) if any level is 0; otherwise clears.
- FSM (registered; the new state appears the cycle after the cause; priority top-down):
  - any state -> DEATH when the starvation counter reaches DEATH_TICKS. DEATH is absorbing until reset.
  - IDLE -> NEUTRAL on the first tick after reset.
  - SLEEP -> wake on btn_awake, or when level 0 reaches MAX. On waking, go to NEEDY if any need_low bit is set, else NEUTRAL.
  - NEUTRAL/NEEDY -> SLEEP on btn_sleep.
  - If btn_sleep and btn_awake arrive in the same cycle, awake wins: a sleeping pet wakes, otherwise no change.
  - NEUTRAL <-> NEEDY follows the OR of need_low.
- Buttons in IDLE are ignored, except btn_test.

Optional Feature:
PET_AUTOSLEEP_EN
- Defined: in NEUTRAL/NEEDY, when level 0 (rest) reaches 0, the FSM enters SLEEP on the next cycle. Rest at 0 does not count toward starvation.
- Undefined: there is no automatic sleep, and rest at 0 counts toward starvation like any other need.

Decomposition:
- Package pet_pkg:
  - state localparams ST_IDLE=0, ST_NEUTRAL=1, ST_NEEDY=2, ST_SLEEP=3, ST_DEATH=4;
  - need indices NEED_REST=0, NEED_FOOD=1, NEED_FUN=2;
  - state width 3.
- Sub-module pet_tick_gen: prescaler plus speed register (TICK_DIV, TEST_W), producing tick.

Test Plan:
All scenarios use the default parameters; MAX=7.
1. Reset held low 50 cycles -> state=IDLE, levels 7/7/7, need_low=000. After release, first tick at cycle 20 -> state=NEUTRAL.
2. No inputs -> after 5 ticks (100 cycles) levels 2/2/2, need_low=111, state=NEEDY on the cycle after the 5th tick.
3. btn_test with test_speed=9 -> tick every 2 cycles. btn_test with test_speed=0 -> tick every 20 cycles again.
4. Food at 1, btn_care[1] coincident with tick -> food=2. Food at 7, btn_care[1] with no tick -> stays 7.
5. btn_sleep in NEUTRAL -> SLEEP; rest rises by 1 per tick, food falls every 2nd tick; rest reaches 7 -> exits SLEEP. btn_sleep+btn_awake together while sleeping -> wakes.
6. Food held at 0 for 4 ticks -> state=DEATH. Care and sleep pulses are ignored and levels stay frozen. rst pulse low -> IDLE with levels 7.
